// File: rtl/mux4_arb_pkg.sv
// Shared definitions for four-way round-robin arbiters: state encoding, index width,
// and conversions between leg index, one-hot grant and the {s0,s1} select pair.
package mux4_arb_pkg;

  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [3:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  // {s0,s1} is simply the leg index with s0 as the MSB.
  function automatic logic [1:0] idx_to_sel(input logic [IDX_W-1:0] idx);
    return idx;
  endfunction

  function automatic logic [IDX_W-1:0] sel_to_idx(input logic [1:0] sel);
    return sel;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Purpose: combinational four-way round-robin picker, first set request at or above ptr.
// Latency: zero cycles (pure combinational).
// Backpressure: none; found is low when no request is set.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [3:0]       rot;
  logic [IDX_W-1:0] off;

  // Rotating the doubled vector puts the ptr requester at bit 0.
  always_comb begin
    rot   = 4'({req, req} >> ptr);
    found = |req;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    idx = ptr + off;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Purpose: round-robin owner of a 4:1 mux; drives select lines and y with valid/ready.
// Latency: grant one cycle after req in IDLE; one IDLE bubble between grants.
// Backpressure: dst_ready low stalls without limit; MUX4_ARB_HOLD_LIMIT_EN caps transfers per grant.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic              dst_ready,
  output logic [3:0]        grant,
  output logic              s0,
  output logic              s1,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             in_grant;
  logic             owner_req;
  logic             limit_hit;
  logic             release_now;
  logic [DATA_W-1:0] leg;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_grant    = (state_q == GRANT);
  assign owner_req   = req[owner_q];
  assign y_valid     = in_grant && owner_req;
  assign busy        = in_grant;
  assign grant       = grant_q;
  assign s0          = sel_q[1];
  assign s1          = sel_q[0];
  assign release_now = in_grant && (!owner_req || limit_hit);

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt_q;
  logic       xfer;

  assign xfer      = y_valid && dst_ready;
  assign limit_hit = xfer && (hold_cnt_q == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           hold_cnt_q <= '0;
    else if (release_now) hold_cnt_q <= '0;
    else if (xfer)        hold_cnt_q <= hold_cnt_q + 8'd1;
  end
`else
  logic cfg_unused;

  assign limit_hit  = 1'b0;
  assign cfg_unused = dst_ready & (MAX_HOLD > 0);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        if (pick_found) begin
          state_d = GRANT;
          grant_d = idx_to_onehot(pick_idx);
          sel_d   = idx_to_sel(pick_idx);
          owner_d = pick_idx;
        end
      end
      GRANT: begin
        // The released owner moves to the back of the rotation.
        if (release_now) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ptr_d   = owner_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    case (sel_to_idx(sel_q))
      2'd0:    leg = a;
      2'd1:    leg = b;
      2'd2:    leg = c;
      default: leg = d;
    endcase
    y = y_valid ? leg : '0;
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vectors with literal expectations plus a
// per-cycle comparison against a request-level arbitration model.
module tb_mux4_rr_arbiter;

  localparam int DW          = 8;
  localparam int TB_MAX_HOLD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [DW-1:0] a = '0, b = '0, c = '0, d = '0;
  logic          dst_ready = 1'b0;
  logic [3:0]    grant;
  logic          s0, s1, y_valid, busy;
  logic [DW-1:0] y;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .dst_ready (dst_ready),
    .grant     (grant),
    .s0        (s0),
    .s1        (s1),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] leg_val(input int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  // Model: who owns the mux, where the rotation starts, how many transfers so far.
  int m_busy = 0, m_owner = 0, m_ptr = 0, m_cnt = 0, m_leg = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_leg = 0;
      end else if (m_busy != 0) begin
        if (!req[m_owner]) begin
          m_busy = 0; m_ptr = (m_owner + 1) % 4; m_cnt = 0;
        end else if (dst_ready) begin
          m_cnt++;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          if (m_cnt == TB_MAX_HOLD) begin
            m_busy = 0; m_ptr = (m_owner + 1) % 4; m_cnt = 0;
          end
`endif
        end
      end else begin
        for (int o = 0; o < 4; o++) begin
          if (m_busy == 0 && req[(m_ptr + o) % 4]) begin
            m_busy  = 1;
            m_owner = (m_ptr + o) % 4;
            m_leg   = m_owner;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      logic [3:0]    e_grant;
      logic          e_yv;
      logic [DW-1:0] e_y;
      @(negedge clk);
      e_grant = (m_busy != 0) ? 4'(1 << m_owner) : 4'b0000;
      e_yv    = (m_busy != 0) && req[m_owner];
      e_y     = e_yv ? leg_val(m_leg) : '0;
      chk("model_grant", grant, e_grant);
      chk("model_s0", s0, m_leg / 2);
      chk("model_s1", s1, m_leg % 2);
      chk("model_y_valid", y_valid, e_yv);
      chk("model_y", y, e_y);
      chk("model_busy", busy, m_busy);
    end
  end

  initial begin
    logic [3:0] rr_exp [5];
    int n;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    a = 8'hA1; b = 8'hB2; c = 8'h5A; d = 8'h3C;
    req = 4'b1111; dst_ready = 1'b1; rst_n = 1'b0;
    step(); step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_s0", s0, 1'b0);
    chk("rst_s1", s1, 1'b0);
    chk("rst_y_valid", y_valid, 1'b0);
    chk("rst_y", y, 8'h00);
    chk("rst_busy", busy, 1'b0);

    rst_n = 1'b1;
    step();
    chk("first_grant", grant, 4'b0001);
    chk("first_sel", {s0, s1}, 2'b00);
    chk("first_y", y, 8'hA1);

    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", grant, rr_exp[i]);
      chk("rr_y_valid", y_valid, 1'b1);
      step();
      req = 4'b1111 & ~rr_exp[i];
      step();
      chk("rr_bubble", grant, 4'b0000);
      req = 4'b1111;
      step();
    end
    req = 4'b0000;
    step();
    chk("rr_idle", grant, 4'b0000);

    req = 4'b0100;
    step();
    chk("sel_c_grant", grant, 4'b0100);
    chk("sel_c_s0", s0, 1'b1);
    chk("sel_c_s1", s1, 1'b0);
    chk("sel_c_y", y, 8'h5A);
    req = 4'b0000;
    step();
    chk("idle_grant", grant, 4'b0000);
    chk("idle_sel_held", {s0, s1}, 2'b10);
    chk("idle_y", y, 8'h00);
    req = 4'b0010;
    step();
    chk("sel_b_s0", s0, 1'b0);
    chk("sel_b_s1", s1, 1'b1);
    chk("sel_b_y", y, 8'hB2);
    req = 4'b0000;
    step();

    req = 4'b1001; dst_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_grant", grant, 4'b1000);
      chk("stall_y_valid", y_valid, 1'b1);
      chk("stall_y", y, 8'h3C);
      step();
    end
    dst_ready = 1'b1;
    step();
    chk("xfer1_grant", grant, 4'b1000);
    step();
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    chk("hold_release", grant, 4'b0000);
    step();
    chk("hold_next_a", grant, 4'b0001);
`else
    chk("no_limit_hold", grant, 4'b1000);
    step();
    chk("no_limit_hold2", grant, 4'b1000);
`endif

    req = 4'b1000;
    n = 0;
    while (grant != 4'b1000 && n < 10) begin
      step();
      n++;
    end
    chk("d_owner_wait", grant, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 4'b0000);
    chk("arst_y_valid", y_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_y", y, 8'h00);
    req = 4'b1001;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("restart_grant", grant, 4'b0001);
    chk("restart_sel", {s0, s1}, 2'b00);
    req = 4'b0000;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
